// File: rtl/shift_seq_ctrl.sv
// Two-requester round-robin serial shift sequencer: accepts a parallel frame,
// shifts it out MSB first while capturing sin, then enforces an idle gap.
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic             sin,
  output logic             sout,
  output logic             busy,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_src
);

  localparam int CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = GAP_M1[3:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    cnt_r;
  logic [3:0]       gap_r;
  logic [WIDTH-1:0] shreg_r;
  logic             owner_r;
  logic             last_r;
  logic [WIDTH-1:0] rx_data_r;
  logic             rx_src_r;
  logic             rx_valid_r;
  logic             grant_s;
  logic             hs_s;
  logic             cap_s;

  // Arbitration, handshake and next-state decode
  always_comb begin
    grant_s    = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    state_s    = state_r;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    if (state_r == S_IDLE) begin
      req0_ready = req0_valid & ~grant_s;
      req1_ready = req1_valid &  grant_s;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
    hs_s  = req0_ready | req1_ready;
    cap_s = (state_r == S_SHIFT) && (cnt_r == CNT_LAST);
    case (state_r)
      S_IDLE: begin
        if (hs_s) state_s = S_SHIFT;
        else      state_s = S_IDLE;
      end
      S_SHIFT: begin
        if (cap_s) state_s = (GAP > 0) ? S_GAP : S_IDLE;
        else       state_s = S_SHIFT;
      end
      S_GAP: begin
        if (gap_r == GAP_LAST) state_s = S_IDLE;
        else                   state_s = S_GAP;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_s;
  end

  // Shift datapath, bit/gap counters and grant history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_r <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      gap_r   <= 4'd0;
      owner_r <= 1'b0;
      last_r  <= 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (hs_s) begin
            shreg_r <= grant_s ? req1_data : req0_data;
            cnt_r   <= {CW{1'b0}};
            owner_r <= grant_s;
            last_r  <= grant_s;
          end
        end
        S_SHIFT: begin
          shreg_r <= {shreg_r[WIDTH-2:0], sin};
          cnt_r   <= cnt_r + CW'(1);
          gap_r   <= 4'd0;
        end
        S_GAP: begin
          gap_r <= gap_r + 4'd1;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Receive capture: the final sin bit is folded in at the closing edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_r  <= {WIDTH{1'b0}};
      rx_src_r   <= 1'b0;
      rx_valid_r <= 1'b0;
    end else begin
      rx_valid_r <= cap_s;
      if (cap_s) begin
        rx_data_r <= {shreg_r[WIDTH-2:0], sin};
        rx_src_r  <= owner_r;
      end
    end
  end

  assign sout     = (state_r == S_SHIFT) ? shreg_r[WIDTH-1] : 1'b0;
  assign busy     = (state_r != S_IDLE);
  assign rx_data  = rx_data_r;
  assign rx_src   = rx_src_r;
  assign rx_valid = rx_valid_r;

endmodule
